// File: rtl/idma_2d_splitter_if.sv
// Handshake bundle between a 2D job source, the splitter, the 1D legalizer and the backend.
// The splitter connects through the slave modport; whoever drives jobs uses master.
interface idma_2d_splitter_if #(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 32,
  parameter int RepWidth  = 16,
  parameter int OptWidth  = 64
);
  logic [LenWidth-1:0]  nd_length_i;
  logic [AddrWidth-1:0] nd_src_addr_i;
  logic [AddrWidth-1:0] nd_dst_addr_i;
  logic [AddrWidth-1:0] nd_src_stride_i;
  logic [AddrWidth-1:0] nd_dst_stride_i;
  logic [RepWidth-1:0]  nd_reps_i;
  logic [OptWidth-1:0]  nd_opt_i;
  logic                 nd_valid_i;
  logic                 nd_ready_o;

  logic [LenWidth-1:0]  burst_length_o;
  logic [AddrWidth-1:0] burst_src_addr_o;
  logic [AddrWidth-1:0] burst_dst_addr_o;
  logic [OptWidth-1:0]  burst_opt_o;
  logic                 burst_last_o;
  logic                 burst_valid_o;
  logic                 burst_ready_i;

  logic                 bk_rsp_valid_i;
  logic                 bk_rsp_last_i;

  logic                 nd_rsp_valid_o;
  logic                 nd_rsp_ready_i;

  logic                 kill_i;
  logic                 busy_o;

  modport slave (
    input  nd_length_i, nd_src_addr_i, nd_dst_addr_i, nd_src_stride_i, nd_dst_stride_i,
    input  nd_reps_i, nd_opt_i, nd_valid_i,
    output nd_ready_o,
    output burst_length_o, burst_src_addr_o, burst_dst_addr_o, burst_opt_o,
    output burst_last_o, burst_valid_o,
    input  burst_ready_i,
    input  bk_rsp_valid_i, bk_rsp_last_i,
    output nd_rsp_valid_o,
    input  nd_rsp_ready_i,
    input  kill_i,
    output busy_o
  );

  modport master (
    output nd_length_i, nd_src_addr_i, nd_dst_addr_i, nd_src_stride_i, nd_dst_stride_i,
    output nd_reps_i, nd_opt_i, nd_valid_i,
    input  nd_ready_o,
    input  burst_length_o, burst_src_addr_o, burst_dst_addr_o, burst_opt_o,
    input  burst_last_o, burst_valid_o,
    output burst_ready_i,
    output bk_rsp_valid_i, bk_rsp_last_i,
    input  nd_rsp_valid_o,
    output nd_rsp_ready_i,
    output kill_i,
    input  busy_o
  );
endinterface

// File: rtl/idma_2d_splitter.sv
// Splits a strided 2D copy job into one 1D burst per row and tracks job completions
// so that each accepted job produces exactly one 2D response (killed jobs produce none).
module idma_2d_splitter #(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 32,
  parameter int RepWidth  = 16,
  parameter int OptWidth  = 64,
  parameter int MaxJobs   = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  idma_2d_splitter_if.slave bus
);

  localparam int CntWidth = $clog2(MaxJobs + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxJobs);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state;
  logic [LenWidth-1:0]  length;
  logic [AddrWidth-1:0] src_addr;
  logic [AddrWidth-1:0] dst_addr;
  logic [AddrWidth-1:0] src_stride;
  logic [AddrWidth-1:0] dst_stride;
  logic [OptWidth-1:0]  opt;
  logic [RepWidth-1:0]  rows_left;
  logic [CntWidth-1:0]  outstanding;
  logic [CntWidth-1:0]  done;
  logic [CntWidth-1:0]  outstanding_next;
  logic [CntWidth-1:0]  done_next;

  logic nd_hs;
  logic burst_hs;
  logic rsp_hs;
  logic kill_emit;
  logic zero_len_acc;
  logic bk_done;

  assign bus.nd_ready_o = !rst_i && (state == IDLE) && (outstanding < MaxCnt) && !bus.kill_i;
  assign nd_hs          = bus.nd_valid_i & bus.nd_ready_o;
  assign zero_len_acc   = nd_hs & (bus.nd_length_i == '0);
  assign burst_hs       = bus.burst_valid_o & bus.burst_ready_i;
  assign kill_emit      = (state == EMIT) & bus.kill_i;
  assign bk_done        = bus.bk_rsp_valid_i & bus.bk_rsp_last_i;
  assign rsp_hs         = bus.nd_rsp_valid_o & bus.nd_rsp_ready_i;

  // A zero-length job completes at acceptance, so it feeds the done counter directly;
  // a killed job never reaches its last row and is retired from outstanding here instead.
  assign done_next        = done + CntWidth'(bk_done) + CntWidth'(zero_len_acc) - CntWidth'(rsp_hs);
  assign outstanding_next = outstanding + CntWidth'(nd_hs) - CntWidth'(rsp_hs) - CntWidth'(kill_emit);

  assign bus.burst_valid_o    = (state == EMIT) & !bus.kill_i;
  assign bus.burst_last_o     = (state == EMIT) & (rows_left == RepWidth'(1));
  assign bus.burst_length_o   = length;
  assign bus.burst_src_addr_o = src_addr;
  assign bus.burst_dst_addr_o = dst_addr;
  assign bus.burst_opt_o      = opt;
  assign bus.nd_rsp_valid_o   = (done != '0);
  assign bus.busy_o           = (state != IDLE) | (outstanding != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      length      <= '0;
      src_addr    <= '0;
      dst_addr    <= '0;
      src_stride  <= '0;
      dst_stride  <= '0;
      opt         <= '0;
      rows_left   <= '0;
      outstanding <= '0;
      done        <= '0;
    end else begin
      outstanding <= outstanding_next;
      done        <= done_next;
      case (state)
        IDLE: begin
          if (nd_hs) begin
            length     <= bus.nd_length_i;
            src_addr   <= bus.nd_src_addr_i;
            dst_addr   <= bus.nd_dst_addr_i;
            src_stride <= bus.nd_src_stride_i;
            dst_stride <= bus.nd_dst_stride_i;
            opt        <= bus.nd_opt_i;
            rows_left  <= (bus.nd_reps_i == '0) ? RepWidth'(1) : bus.nd_reps_i;
            if (bus.nd_length_i != '0) begin
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (kill_emit) begin
            state     <= IDLE;
            rows_left <= '0;
          end else if (burst_hs) begin
            src_addr  <= src_addr + src_stride;
            dst_addr  <= dst_addr + dst_stride;
            rows_left <= rows_left - RepWidth'(1);
            if (rows_left == RepWidth'(1)) begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idma_2d_splitter.sv
// Directed bench for idma_2d_splitter: row addressing, stalls, job limit, kill, wrap and reset.
module tb_idma_2d_splitter;
  localparam int AddrWidth = 32;
  localparam int LenWidth  = 32;
  localparam int RepWidth  = 16;
  localparam int OptWidth  = 64;
  localparam int MaxJobs   = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  logic [AddrWidth-1:0] hs_src  [8];
  logic [AddrWidth-1:0] hs_dst  [8];
  logic                 hs_last [8];

  always #5 clk_i = ~clk_i;

  idma_2d_splitter_if #(
    .AddrWidth(AddrWidth), .LenWidth(LenWidth), .RepWidth(RepWidth), .OptWidth(OptWidth)
  ) bus ();

  idma_2d_splitter #(
    .AddrWidth(AddrWidth), .LenWidth(LenWidth), .RepWidth(RepWidth),
    .OptWidth(OptWidth), .MaxJobs(MaxJobs)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a job and waits a bounded number of cycles for it to be taken.
  task automatic applyStimulus(input logic [31:0] len, input logic [31:0] src, input logic [31:0] dst,
                               input logic [31:0] sstr, input logic [31:0] dstr,
                               input logic [15:0] reps, input logic [63:0] opt);
    bit accepted;
    accepted = 1'b0;
    bus.nd_length_i     = len;
    bus.nd_src_addr_i   = src;
    bus.nd_dst_addr_i   = dst;
    bus.nd_src_stride_i = sstr;
    bus.nd_dst_stride_i = dstr;
    bus.nd_reps_i       = reps;
    bus.nd_opt_i        = opt;
    bus.nd_valid_i      = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      if (bus.nd_ready_o) accepted = 1'b1;
      tick();
    end
    bus.nd_valid_i = 1'b0;
    checkOutput("nd_accept", 64'(accepted), 64'd1);
  endtask

  // Consumes the rows of the current job with a directed ready pattern, checking every
  // presented burst against the expected row and recording each handshake.
  task automatic runRows(input logic [31:0] len, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] sstr, input logic [31:0] dstr, input int rows,
                         input logic [63:0] opt, input logic [15:0] pattern);
    logic [31:0] exp_src;
    logic [31:0] exp_dst;
    int idx;
    exp_src = src;
    exp_dst = dst;
    idx = 0;
    for (int cyc = 0; cyc < 64 && idx < rows; cyc++) begin
      bus.burst_ready_i = pattern[cyc % 16];
      #1;
      if (cyc == 0) checkOutput("first_valid", 64'(bus.burst_valid_o), 64'd1);
      if (bus.burst_valid_o) begin
        checkOutput("burst_src", 64'(bus.burst_src_addr_o), 64'(exp_src));
        checkOutput("burst_dst", 64'(bus.burst_dst_addr_o), 64'(exp_dst));
        checkOutput("burst_len", 64'(bus.burst_length_o), 64'(len));
        checkOutput("burst_opt", bus.burst_opt_o, opt);
        checkOutput("burst_last", 64'(bus.burst_last_o), 64'(idx == rows - 1));
        if (bus.burst_ready_i) begin
          hs_src[idx]  = bus.burst_src_addr_o;
          hs_dst[idx]  = bus.burst_dst_addr_o;
          hs_last[idx] = bus.burst_last_o;
          idx++;
          exp_src = exp_src + sstr;
          exp_dst = exp_dst + dstr;
        end
      end
      tick();
    end
    bus.burst_ready_i = 1'b1;
    checkOutput("row_count", 64'(idx), 64'(rows));
    #1;
    checkOutput("valid_after_job", 64'(bus.burst_valid_o), 64'd0);
  endtask

  task automatic sendBkRsp(input logic last);
    bus.bk_rsp_valid_i = 1'b1;
    bus.bk_rsp_last_i  = last;
    tick();
    bus.bk_rsp_valid_i = 1'b0;
    bus.bk_rsp_last_i  = 1'b0;
  endtask

  task automatic ndRspHandshake();
    bus.nd_rsp_ready_i = 1'b1;
    #1;
    checkOutput("nd_rsp_valid", 64'(bus.nd_rsp_valid_o), 64'd1);
    tick();
    bus.nd_rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i              = 1'b1;
    bus.nd_length_i     = '0;
    bus.nd_src_addr_i   = '0;
    bus.nd_dst_addr_i   = '0;
    bus.nd_src_stride_i = '0;
    bus.nd_dst_stride_i = '0;
    bus.nd_reps_i       = '0;
    bus.nd_opt_i        = '0;
    bus.nd_valid_i      = 1'b0;
    bus.burst_ready_i   = 1'b0;
    bus.bk_rsp_valid_i  = 1'b0;
    bus.bk_rsp_last_i   = 1'b0;
    bus.nd_rsp_ready_i  = 1'b0;
    bus.kill_i          = 1'b0;
    tick();
    tick();

    checkOutput("rst_nd_ready", 64'(bus.nd_ready_o), 64'd0);
    checkOutput("rst_burst_valid", 64'(bus.burst_valid_o), 64'd0);
    checkOutput("rst_burst_last", 64'(bus.burst_last_o), 64'd0);
    checkOutput("rst_nd_rsp_valid", 64'(bus.nd_rsp_valid_o), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("rst_src", 64'(bus.burst_src_addr_o), 64'd0);
    checkOutput("rst_dst", 64'(bus.burst_dst_addr_o), 64'd0);
    checkOutput("rst_len", 64'(bus.burst_length_o), 64'd0);
    checkOutput("rst_opt", bus.burst_opt_o, 64'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_nd_ready", 64'(bus.nd_ready_o), 64'd1);
    tick();

    // Three rows with distinct strides, always ready
    applyStimulus(32'd64, 32'h1000, 32'h8000, 32'h100, 32'h200, 16'd3, 64'hDEAD_BEEF_0123_4567);
    runRows(32'd64, 32'h1000, 32'h8000, 32'h100, 32'h200, 3, 64'hDEAD_BEEF_0123_4567, 16'hFFFF);
    checkOutput("r0_src", 64'(hs_src[0]), 64'h1000);
    checkOutput("r0_dst", 64'(hs_dst[0]), 64'h8000);
    checkOutput("r1_src", 64'(hs_src[1]), 64'h1100);
    checkOutput("r1_dst", 64'(hs_dst[1]), 64'h8200);
    checkOutput("r2_src", 64'(hs_src[2]), 64'h1200);
    checkOutput("r2_dst", 64'(hs_dst[2]), 64'h8400);
    checkOutput("r0_last", 64'(hs_last[0]), 64'd0);
    checkOutput("r1_last", 64'(hs_last[1]), 64'd0);
    checkOutput("r2_last", 64'(hs_last[2]), 64'd1);
    checkOutput("job_busy", 64'(bus.busy_o), 64'd1);
    sendBkRsp(1'b0);
    sendBkRsp(1'b0);
    #1;
    checkOutput("rsp_not_yet", 64'(bus.nd_rsp_valid_o), 64'd0);
    sendBkRsp(1'b1);
    #1;
    checkOutput("rsp_after_last", 64'(bus.nd_rsp_valid_o), 64'd1);
    ndRspHandshake();
    #1;
    checkOutput("idle_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("rsp_cleared", 64'(bus.nd_rsp_valid_o), 64'd0);

    // reps=0 behaves as a single row
    applyStimulus(32'd16, 32'h2000, 32'h3000, 32'h40, 32'h40, 16'd0, 64'h1);
    runRows(32'd16, 32'h2000, 32'h3000, 32'h40, 32'h40, 1, 64'h1, 16'hFFFF);
    checkOutput("reps0_last", 64'(hs_last[0]), 64'd1);
    sendBkRsp(1'b1);
    #1;
    checkOutput("reps0_rsp", 64'(bus.nd_rsp_valid_o), 64'd1);
    ndRspHandshake();

    // Stalled consumer: ready pattern 0,1,0,0,1,0,1,1
    applyStimulus(32'd128, 32'h4000, 32'h5000, 32'h10, 32'h20, 16'd4, 64'h22);
    runRows(32'd128, 32'h4000, 32'h5000, 32'h10, 32'h20, 4, 64'h22, 16'b1011_0100_1101_0010);
    checkOutput("stall_r3_src", 64'(hs_src[3]), 64'h4030);
    checkOutput("stall_r3_dst", 64'(hs_dst[3]), 64'h5060);
    sendBkRsp(1'b1);
    ndRspHandshake();

    // Job limit: four single-row jobs without responses block the fifth
    for (int j = 0; j < 4; j++) begin
      applyStimulus(32'd8, 32'(j * 32'h100), 32'h9000, 32'h0, 32'h0, 16'd1, 64'h0);
      runRows(32'd8, 32'(j * 32'h100), 32'h9000, 32'h0, 32'h0, 1, 64'h0, 16'hFFFF);
    end
    bus.nd_length_i     = 32'd8;
    bus.nd_src_addr_i   = 32'h900;
    bus.nd_dst_addr_i   = 32'hA00;
    bus.nd_src_stride_i = 32'h0;
    bus.nd_dst_stride_i = 32'h0;
    bus.nd_reps_i       = 16'd1;
    bus.nd_opt_i        = 64'h5;
    bus.nd_valid_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("fifth_blocked", 64'(bus.nd_ready_o), 64'd0);
      tick();
    end
    sendBkRsp(1'b1);
    #1;
    checkOutput("fifth_still_blocked", 64'(bus.nd_ready_o), 64'd0);
    ndRspHandshake();
    #1;
    checkOutput("fifth_ready", 64'(bus.nd_ready_o), 64'd1);
    tick();
    bus.nd_valid_i = 1'b0;
    runRows(32'd8, 32'h900, 32'hA00, 32'h0, 32'h0, 1, 64'h5, 16'hFFFF);
    for (int j = 0; j < 4; j++) sendBkRsp(1'b1);
    for (int j = 0; j < 4; j++) ndRspHandshake();
    #1;
    checkOutput("limit_drained_busy", 64'(bus.busy_o), 64'd0);

    // Kill during row 2 of a five-row job
    applyStimulus(32'd32, 32'h6000, 32'h7000, 32'h80, 32'h80, 16'd5, 64'h0);
    bus.burst_ready_i = 1'b1;
    #1;
    checkOutput("kill_row1_valid", 64'(bus.burst_valid_o), 64'd1);
    tick();
    bus.kill_i = 1'b1;
    #1;
    checkOutput("kill_valid_low", 64'(bus.burst_valid_o), 64'd0);
    checkOutput("kill_row2_src", 64'(bus.burst_src_addr_o), 64'h6080);
    tick();
    bus.kill_i = 1'b0;
    #1;
    checkOutput("kill_idle_valid", 64'(bus.burst_valid_o), 64'd0);
    checkOutput("kill_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("kill_nd_ready", 64'(bus.nd_ready_o), 64'd1);
    sendBkRsp(1'b0);
    #1;
    checkOutput("kill_no_rsp", 64'(bus.nd_rsp_valid_o), 64'd0);
    tick();
    checkOutput("kill_no_rsp_later", 64'(bus.nd_rsp_valid_o), 64'd0);
    bus.kill_i = 1'b1;
    #1;
    checkOutput("kill_in_idle_ready", 64'(bus.nd_ready_o), 64'd0);
    checkOutput("kill_in_idle_busy", 64'(bus.busy_o), 64'd0);
    tick();
    bus.kill_i = 1'b0;
    #1;
    checkOutput("kill_in_idle_after", 64'(bus.nd_ready_o), 64'd1);

    // Address wrap and zero-length job
    applyStimulus(32'd4, 32'hFFFF_FFF0, 32'h10, 32'h20, 32'h20, 16'd2, 64'h0);
    runRows(32'd4, 32'hFFFF_FFF0, 32'h10, 32'h20, 32'h20, 2, 64'h0, 16'hFFFF);
    checkOutput("wrap_r0_src", 64'(hs_src[0]), 64'hFFFF_FFF0);
    checkOutput("wrap_r1_src", 64'(hs_src[1]), 64'h0000_0010);
    sendBkRsp(1'b1);
    ndRspHandshake();
    applyStimulus(32'd0, 32'h1, 32'h2, 32'h0, 32'h0, 16'd3, 64'h0);
    #1;
    checkOutput("zero_len_no_burst", 64'(bus.burst_valid_o), 64'd0);
    checkOutput("zero_len_rsp", 64'(bus.nd_rsp_valid_o), 64'd1);
    checkOutput("zero_len_busy", 64'(bus.busy_o), 64'd1);
    ndRspHandshake();
    #1;
    checkOutput("zero_len_done_busy", 64'(bus.busy_o), 64'd0);

    // Asynchronous reset in the middle of a job
    applyStimulus(32'd8, 32'hA000, 32'hB000, 32'h4, 32'h4, 16'd3, 64'h7);
    bus.burst_ready_i = 1'b1;
    tick();
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(bus.burst_valid_o), 64'd0);
    checkOutput("midrst_last", 64'(bus.burst_last_o), 64'd0);
    checkOutput("midrst_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("midrst_src", 64'(bus.burst_src_addr_o), 64'd0);
    checkOutput("midrst_nd_ready", 64'(bus.nd_ready_o), 64'd0);
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_release_ready", 64'(bus.nd_ready_o), 64'd1);
    checkOutput("midrst_release_valid", 64'(bus.burst_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/idma_2d_splitter.md
IDMA_2D_SPLITTER -- requirements
Module: idma_2d_splitter

Interface
REQ-001 SHALL have parameter AddrWidth, 32, byte-address width of the source, destination and stride fields.
REQ-002 SHALL have parameter LenWidth, 32, transfer length width in bytes.
REQ-003 SHALL have parameter RepWidth, 16, repetition count width.
REQ-004 SHALL have parameter OptWidth, 64, width of the opaque options field, passed through unchanged.
REQ-005 SHALL have parameter MaxJobs, 4, maximum number of accepted jobs awaiting a completion response (>=1).
REQ-006 clk_i  in  1  sole clock; all state on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 nd_length_i  in  LenWidth  bytes per row; nd_src_addr_i, nd_dst_addr_i  in  AddrWidth  first-row addresses.
REQ-009 nd_src_stride_i, nd_dst_stride_i  in  AddrWidth  per-row address increments; nd_reps_i  in  RepWidth  row count.
REQ-010 nd_opt_i  in  OptWidth  options; nd_valid_i  in  1, nd_ready_o  out  1  2D request handshake.
REQ-011 burst_length_o  out  LenWidth; burst_src_addr_o, burst_dst_addr_o  out  AddrWidth; burst_opt_o  out  OptWidth: 1D request to the legalizer.
REQ-012 burst_last_o  out  1  final row of a job; burst_valid_o  out  1, burst_ready_i  in  1  1D handshake.
REQ-013 bk_rsp_valid_i  in  1, bk_rsp_last_i  in  1: backend 1D completion (one per accepted 1D, in order; ready implicitly 1).
REQ-014 nd_rsp_valid_o  out  1, nd_rsp_ready_i  in  1: 2D job completion handshake.
REQ-015 kill_i  in  1  abort emission of the current job; busy_o  out  1  FSM not IDLE or jobs outstanding.

Function
REQ-016 FSM SHALL have states IDLE and EMIT.
REQ-017 nd_ready_o SHALL be 1 only in IDLE with outstanding-job counter < MaxJobs and kill_i=0.
REQ-018 On nd handshake: latch all fields; rows_left = (nd_reps_i==0) ? 1 : nd_reps_i; outstanding +1; go EMIT, except nd_length_i==0 -> stay IDLE, no 1D emitted, done counter +1.
REQ-019 In EMIT: burst_valid_o = !kill_i; outputs driven from registers only; burst_last_o = (rows_left==1).
REQ-020 First 1D valid SHALL appear the cycle after nd acceptance (1-cycle latency); one idle cycle between jobs.
REQ-021 On 1D handshake: src += src_stride, dst += dst_stride (modulo 2^AddrWidth, wrap silent); rows_left -1; if rows_left was 1 -> IDLE.
REQ-022 Outputs SHALL hold stable while burst_valid_o=1 and burst_ready_i=0.
REQ-023 bk_rsp_valid_i with bk_rsp_last_i=1 SHALL increment done counter; nd_rsp_valid_o = (done != 0).
REQ-024 nd_rsp handshake SHALL decrement done and outstanding; simultaneous increment and decrement -> done unchanged.
REQ-025 kill_i in EMIT SHALL force IDLE next cycle, discard rows_left, decrement outstanding (last row never issued); kill_i in IDLE no effect.
REQ-026 Counters SHALL be $clog2(MaxJobs+1) bits and never overflow/underflow (guarded by REQ-017).
REQ-027 busy_o = (state != IDLE) | (outstanding != 0).

Reset
REQ-028 rst_i asserted, any cycle including mid-job, SHALL immediately force IDLE, all counters 0, all datapath registers 0.
REQ-029 Reset outputs: nd_ready_o=0 while rst_i=1, then 1; burst_valid_o=0, burst_last_o=0, nd_rsp_valid_o=0, busy_o=0, all data outputs 0.

Verification
REQ-030 len=64, src=0x1000, dst=0x8000, strides 0x100/0x200, reps=3, ready=1 -> 1D addrs (0x1000,0x8000),(0x1100,0x8200),(0x1200,0x8400), last only on third.
REQ-031 reps=0, len=16 -> exactly one 1D with last=1; after bk_rsp last -> nd_rsp_valid_o=1 next cycle.
REQ-032 burst_ready_i toggled randomly during reps=4 job -> outputs stable while stalled, exactly 4 handshakes, no duplicate.
REQ-033 MaxJobs=4, five jobs, no bk_rsp -> fifth nd_valid_i held with nd_ready_o=0 until one nd_rsp handshake.
REQ-034 kill_i during row 2 of reps=5 -> burst_valid_o=0 that cycle, IDLE next, outstanding back to prior value, no nd_rsp for that job.
REQ-035 src=0xFFFF_FFF0, stride 0x20 -> second row src=0x0000_0010; len=0 job -> no 1D, nd_rsp_valid_o raised.
